// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// mult/multu: radix-2 shift-add over 32 cycles; div/divu: restoring division over
// 32 cycles. Both work on operand magnitudes, and the sign is fixed up in a final FIX cycle.
// mthi/mtlo write HI/LO directly at the accepting edge.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       MDctr,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [4:0]         cnt;
  logic               is_div, neg_res, neg_rem, b_zero;
  logic [WIDTH-1:0]   ma, mb, acc_hi, acc_lo;

  logic               go, md_go, sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_r;
  logic [WIDTH-1:0]   div_d, step_hi, step_lo;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign go    = start && (state == IDLE);
  assign md_go = go && !MDctr[2];

  // Signed ops use magnitudes; unsigned ops never see a sign.
  assign sa    = !MDctr[0] && A[WIDTH-1];
  assign sb    = !MDctr[0] && B[WIDTH-1];
  assign abs_a = sa ? -A : A;
  assign abs_b = sb ? -B : B;

  // One iteration. Multiply keeps the multiplier in acc_lo and shifts the product in
  // from the top. Divide shifts the dividend out of acc_lo into the remainder and
  // shifts quotient bits into acc_lo.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, ma} : '0);
  assign div_r   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge  = div_r >= {1'b0, mb};
  assign div_d   = div_r[WIDTH-1:0] - mb;   // the result fits in WIDTH bits whenever div_ge holds
  assign step_hi = is_div ? (div_ge ? div_d : div_r[WIDTH-1:0]) : mul_sum[WIDTH:1];
  assign step_lo = is_div ? {acc_lo[WIDTH-2:0], div_ge} : {mul_sum[0], acc_lo[WIDTH-1:1]};

  // Sign correction. Division by zero yields an all-ones quotient regardless of sign.
  // Its remainder equals the dividend magnitude, so re-applying the dividend sign
  // restores A.
  assign prod   = {acc_hi, acc_lo};
  assign prod_s = neg_res ? -prod : prod;
  always_comb begin
    res_hi = prod_s[2*WIDTH-1:WIDTH];
    res_lo = prod_s[WIDTH-1:0];
    if (is_div) begin
      res_hi = neg_rem ? -acc_hi : acc_hi;
      res_lo = b_zero ? '1 : (neg_res ? -acc_lo : acc_lo);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: 32 RUN cycles, then a single FIX cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (md_go) state_nxt = RUN;
      RUN:     if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, result write and the registered done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      ma      <= '0;
      mb      <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      HI      <= '0;
      LO      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (go) begin
          case (MDctr)
            3'b100: HI <= A;
            3'b101: LO <= A;
            3'b000, 3'b001, 3'b010, 3'b011: begin
              is_div  <= MDctr[1];
              neg_res <= sa ^ sb;
              neg_rem <= sa;
              b_zero  <= (B == '0);
              ma      <= abs_a;
              mb      <= abs_b;
              acc_hi  <= '0;
              acc_lo  <= MDctr[1] ? abs_a : abs_b;
              cnt     <= '0;
            end
            default: ;
          endcase
        end
        RUN: begin
          cnt    <= cnt + 5'd1;
          acc_hi <= step_hi;
          acc_lo <= step_lo;
        end
        FIX: begin
          HI   <= res_hi;
          LO   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // done is registered, so busy is held high through the cycle that carries done
  assign busy = (state != IDLE) || done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random ops, each checked
// against an arithmetic reference model cycle by cycle for busy/done/HI/LO.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] A, B;
  logic [2:0]  MDctr;
  logic        busy, done;
  logic [31:0] HI, LO;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDctr(MDctr), .start(start),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {HI, LO} for ops 0..3
  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sp;
    int     sa, sbv;
    sa  = a;
    sbv = b;
    case (op)
      3'd0: begin sp = longint'(sa) * longint'(sbv); return sp; end
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sbv), 32'(sa / sbv)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Iterative op. inj_k: cycle in which a stray start is raised (0 = none).
  // rst_k: cycle in which reset is pulsed (0 = none).
  task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int inj_k, input int rst_k);
    logic [63:0] e;
    e = ref_op(op, a, b);
    @(negedge clk);
    A = a; B = b; MDctr = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom;
    for (int k = 1; k <= 34; k++) begin
      check("busy", 64'(busy), 64'd1);
      check("done", 64'(done), 64'(k == 34));
      if (k < 34) check("hold", {HI, LO}, {m_hi, m_lo});
      else        check("result", {HI, LO}, e);
      if (k == inj_k) begin
        start = 1'b1; MDctr = 3'($urandom_range(0, 5));
      end
      if (k == rst_k) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        m_hi = '0; m_lo = '0;
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    {m_hi, m_lo} = e;
    check("after_busy", 64'(busy), 64'd0);
    check("after_done", 64'(done), 64'd0);
  endtask

  // Single-edge ops: mthi/mtlo/no-op
  task automatic do_mt(input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    A = a; B = $urandom; MDctr = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (op == 3'd4) m_hi = a;
    if (op == 3'd5) m_lo = a;
    check("mt_busy", 64'(busy), 64'd0);
    check("mt_done", 64'(done), 64'd0);
    check("mt_hilo", {HI, LO}, {m_hi, m_lo});
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; A = '0; B = '0; MDctr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);
    reset = 1'b0;

    do_md(3'd0, 32'hFFFF_FFFE, 32'd3, 0, 0);
    do_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    do_md(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
    do_md(3'd3, 32'd7, 32'd0, 0, 0);
    do_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_md(3'd2, 32'hFFFF_FFFB, 32'd0, 0, 0);
    do_md(3'd0, 32'h8000_0000, 32'h8000_0000, 0, 0);
    do_mt(3'd4, 32'h1234_5678);
    do_mt(3'd5, 32'd5);
    do_mt(3'd6, 32'hDEAD_BEEF);
    do_mt(3'd7, 32'hCAFE_F00D);
    do_md(3'd0, 32'd100, 32'd200, 5, 0);
    do_md(3'd2, 32'd1000, 32'hFFFF_FFF9, 33, 0);
    do_md(3'd1, 32'd1234, 32'd5678, 0, 10);
    do_md(3'd0, 32'hFFFF_FF00, 32'd77, 0, 0);

    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      do_md(3'($urandom_range(0, 3)), ra, rb, (i % 3 == 0) ? int'($urandom_range(1, 33)) : 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand and HI/LO width; only 32 supported.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: A  input  32  operand rs, sampled at accepted start.
REQ-005 SHALL have port: B  input  32  operand rt, sampled at accepted start.
REQ-006 SHALL have port: MDctr  input  3  op select: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others no-op.
REQ-007 SHALL have port: start  input  1  request strobe, one cycle.
REQ-008 SHALL have port: busy  output  1  iterative op in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when HI/LO updated by mult/div.
REQ-010 SHALL have port: HI  output  32  HI register; div remainder or product upper half.
REQ-011 SHALL have port: LO  output  32  LO register; div quotient or product lower half.

Function
REQ-012 SHALL use FSM with states IDLE, RUN, FIX; IDLE is the reset state.
REQ-013 SHALL accept start only in IDLE; start in RUN/FIX is ignored, with no effect on operands or result.
REQ-014 SHALL, on accepted start with MDctr 100/101, write A to HI/LO at that edge, stay IDLE, and leave busy and done at 0.
REQ-015 SHALL, on accepted start with MDctr 000-011, latch operand magnitudes, op and signs, then enter RUN; busy=1 from the next cycle.
REQ-016 SHALL iterate one bit per cycle in RUN for exactly 32 cycles (radix-2 shift-add multiply, restoring divide), then go to FIX.
REQ-017 SHALL in FIX apply sign correction, write HI/LO, pulse done=1 for that cycle, return to IDLE; busy is 1 in RUN and FIX.
REQ-018 SHALL give latency: start edge N -> HI/LO valid and done=1 in cycle N+34; busy high cycles N+1..N+34.
REQ-019 SHALL hold HI/LO at previous values during RUN and FIX until the FIX write.
REQ-020 SHALL mult: {HI,LO} = signed 64-bit A*B; multu: unsigned 64-bit product.
REQ-021 SHALL div: LO = quotient truncated toward zero, HI = remainder with sign of dividend; divu: unsigned.
REQ-022 SHALL div/divu with B=0: LO=32'hFFFF_FFFF, HI=A, same 34-cycle latency.
REQ-023 SHALL div 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
REQ-024 SHALL treat MDctr 110/111 with start as no-op: stay IDLE, no register change.
REQ-025 SHALL keep done low in every cycle except the FIX cycle.

Reset
REQ-026 SHALL on reset=1 at an edge: state IDLE, busy=0, done=0, HI=0, LO=0, iteration counter 0.
REQ-027 SHALL give reset priority over start and over any in-flight op; abort mid-RUN discards the op, with no done pulse.
REQ-028 SHALL accept a start in the first cycle after reset deasserts.

Verification
REQ-029 SHALL cover mult A=32'hFFFF_FFFE (-2), B=3 -> after 34 cycles HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA, done one cycle.
REQ-030 SHALL cover multu A=B=32'hFFFF_FFFF -> HI=32'hFFFF_FFFE, LO=32'h0000_0001.
REQ-031 SHALL cover div A=-7 (32'hFFFF_FFF9), B=2 -> LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1); divu A=7, B=0 -> LO=32'hFFFF_FFFF, HI=7.
REQ-032 SHALL cover mthi A=32'h1234_5678 -> HI updated next edge, busy stays 0; then mtlo A=5 -> LO=5.
REQ-033 SHALL cover start asserted during RUN with different A/B -> ignored; original result delivered at N+34.
REQ-034 SHALL cover reset asserted at RUN cycle 10 -> busy=0, HI=LO=0 next cycle, no done; new mult after reset is correct.
